// File: rtl/dec2_4_pkg.sv
// Shared constants and helpers for the dec2_4 registered select decoder.
package dec2_4_pkg;

  localparam int unsigned DEC_SEL_W   = 2;
  localparam int unsigned SEL_W_MAX   = 4;
  localparam int unsigned OUT_W_MAX   = 16;
  localparam int unsigned POPCNT_W    = 5;

  // One-hot decode at the widest legal width; callers truncate to their own width.
  function automatic logic [OUT_W_MAX-1:0] onehot_dec(input logic [SEL_W_MAX-1:0] sel,
                                                      input logic                 en);
    logic [OUT_W_MAX-1:0] v;
    v = '0;
    if (en) v[sel] = 1'b1;
    return v;
  endfunction

  // Number of set bits in a vector of up to OUT_W_MAX bits.
  function automatic logic [POPCNT_W-1:0] popcount(input logic [OUT_W_MAX-1:0] v);
    logic [POPCNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < int'(OUT_W_MAX); i++) cnt = cnt + POPCNT_W'(v[i]);
    return cnt;
  endfunction

endpackage

// File: rtl/dec2_4_onehot_chk.sv
// Sticky invariant checker: flags a decoded word whose popcount disagrees with a_vld.
module dec2_4_onehot_chk
  import dec2_4_pkg::*;
#(
  parameter int unsigned OUT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OUT_W-1:0] a,
  input  logic             a_vld,
  output logic             err
);

  logic                dec_live;
  logic [POPCNT_W-1:0] pc_c;
  logic                viol_c;

  // Current word is only judged once it came from a decode, not from the reset load.
  always_comb begin
    pc_c   = popcount(OUT_W_MAX'(a));
    viol_c = 1'b0;
    if (dec_live) begin
      if (a_vld) viol_c = (pc_c != POPCNT_W'(1));
      else       viol_c = (pc_c != POPCNT_W'(0));
    end
  end

  // Track whether the output register has been loaded since reset; err is sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_live <= 1'b0;
      err      <= 1'b0;
    end else begin
      dec_live <= 1'b1;
      err      <= err | viol_c;
    end
  end

  // Simulation report of the same invariant violation.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!viol_c) else $error("dec2_4 one-hot invariant violated: a=%0h a_vld=%0b", a, a_vld);
    end
  end

endmodule

// File: rtl/dec2_4.sv
// Registered binary-to-one-hot select decoder with enable.
// Optional invariant checker and err port: define DEC2_4_ONEHOT_CHK_EN.
module dec2_4
  import dec2_4_pkg::*;
#(
  parameter  int unsigned              SEL_W   = DEC_SEL_W,
  localparam int unsigned              OUT_W   = 2 ** SEL_W,
  parameter  logic [(2**SEL_W)-1:0]    RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] b,
  input  logic             en,
  output logic [OUT_W-1:0] a,
  output logic             a_vld
`ifdef DEC2_4_ONEHOT_CHK_EN
  ,
  output logic             err
`endif
);

  logic [OUT_W-1:0] next_a_c;

  // Combinational decode of the select; all zeros when disabled.
  always_comb begin
    next_a_c = OUT_W'(onehot_dec(SEL_W_MAX'(b), en));
  end

  // Output register: one cycle of latency, asynchronous reset to RST_VAL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a     <= RST_VAL;
      a_vld <= 1'b0;
    end else begin
      a     <= next_a_c;
      a_vld <= en;
    end
  end

`ifdef DEC2_4_ONEHOT_CHK_EN
  dec2_4_onehot_chk #(
    .OUT_W (OUT_W)
  ) u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .a_vld (a_vld),
    .err   (err)
  );
`endif

endmodule

// File: tb/tb_dec2_4.sv
// Scoreboard bench for dec2_4: default-width instance plus an 8-output instance.
module tb_dec2_4;

  typedef struct packed {
    logic [3:0] a;
    logic       vld;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [1:0] b;
  logic       en;
  logic [3:0] a;
  logic       a_vld;
  logic [2:0] b3;
  logic       en3;
  logic [7:0] a3;
  logic       a3_vld;
`ifdef DEC2_4_ONEHOT_CHK_EN
  logic       err;
  logic       err3;
`endif

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  dec2_4 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .b     (b),
    .en    (en),
    .a     (a),
    .a_vld (a_vld)
`ifdef DEC2_4_ONEHOT_CHK_EN
    ,
    .err   (err)
`endif
  );

  dec2_4 #(
    .SEL_W   (3),
    .RST_VAL (8'hA5)
  ) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .b     (b3),
    .en    (en3),
    .a     (a3),
    .a_vld (a3_vld)
`ifdef DEC2_4_ONEHOT_CHK_EN
    ,
    .err   (err3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Drive one vector at the falling edge and queue the response due one clock later.
  task automatic apply(input logic [1:0] vb, input logic ven, input logic [3:0] ea);
    exp_t e;
    @(negedge clk);
    b   = vb;
    en  = ven;
    e.a   = ea;
    e.vld = ven;
    q.push_back(e);
  endtask

  // Monitor: compare the registered output just after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("sb_a",     32'(a),     32'(e.a));
      check("sb_a_vld", 32'(a_vld), 32'(e.vld));
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    b = 2'd0; en = 1'b0; b3 = 3'd0; en3 = 1'b0;
    #12;
    check("rst_a",       32'(a),      32'h0);
    check("rst_a_vld",   32'(a_vld),  32'h0);
    check("rst3_a",      32'(a3),     32'hA5);
    check("rst3_a_vld",  32'(a3_vld), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel3_a", 32'(a3), 32'h0);

    // Disabled, full sweep, then en toggling with b=1.
    apply(2'd0, 1'b0, 4'b0000);
    apply(2'd3, 1'b0, 4'b0000);
    apply(2'd0, 1'b1, 4'b0001);
    apply(2'd1, 1'b1, 4'b0010);
    apply(2'd2, 1'b1, 4'b0100);
    apply(2'd3, 1'b1, 4'b1000);
    apply(2'd1, 1'b1, 4'b0010);
    apply(2'd1, 1'b0, 4'b0000);
    apply(2'd1, 1'b1, 4'b0010);
    apply(2'd2, 1'b1, 4'b0100);
    @(posedge clk); #2;
    check("sb_drain", 32'(q.size()), 32'h0);

    // Asynchronous reset mid-cycle with en=1, b=2 held.
    #1;
    rst_n = 1'b0;
    #1;
    check("async_a",     32'(a),     32'h0);
    check("async_a_vld", 32'(a_vld), 32'h0);
    @(posedge clk); #1;
    check("hold_a",      32'(a),     32'h0);
    check("hold_a_vld",  32'(a_vld), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b0;

    // Wider instance: b=5 and top boundary b=7.
    @(negedge clk);
    b3 = 3'd5; en3 = 1'b1;
    @(posedge clk); #1;
    check("w3_a5",     32'(a3),     32'h20);
    check("w3_a5_vld", 32'(a3_vld), 32'h1);
    @(negedge clk);
    b3 = 3'd7;
    @(posedge clk); #1;
    check("w3_a7", 32'(a3), 32'h80);
    @(negedge clk);
    en3 = 1'b0;
    @(posedge clk); #1;
    check("w3_dis", 32'(a3), 32'h0);

`ifdef DEC2_4_ONEHOT_CHK_EN
    // Invariant checker: corrupt a while a_vld is high.
    @(negedge clk);
    b = 2'd0; en = 1'b1;
    @(posedge clk); #1;
    check("chk_clean", 32'(err), 32'h0);
    @(negedge clk);
    force dut.a = 4'b0011;
    @(posedge clk); #1;
    check("chk_err", 32'(err), 32'h1);
    @(negedge clk);
    release dut.a;
    repeat (2) @(posedge clk);
    #1;
    check("chk_sticky", 32'(err), 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("chk_rst", 32'(err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    repeat (2) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
